// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle core memory read return path.
package mcp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic DEST_IR  = 1'b0;
   localparam logic DEST_MDR = 1'b1;

endpackage : mcp_pkg

// File: rtl/mcp_en_reg.sv
// Synchronous-reset register with load enable (used for IR and MDR).
module mcp_en_reg #(
   parameter int unsigned WL = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [WL-1:0] d,
   output logic [WL-1:0] q
);

   // Load on enable, clear on reset, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : mcp_en_reg

// File: rtl/mcp_mem_rd_demux.sv
// Routes the shared memory read stream into IR or MDR with a bounded wait.
module mcp_mem_rd_demux
   import mcp_pkg::*;
#(
   parameter int unsigned WL       = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ,
   input  logic          DEST_SEL,
   output logic          MEM_RE,
   input  logic          MEM_RVALID,
   input  logic [WL-1:0] MEM_RDATA,
   output logic [WL-1:0] IR_out,
   output logic [WL-1:0] MDR_out,
   output logic          BUSY,
   output logic          DONE,
   output logic          TIMEOUT,
   input  logic          CLR_ERR
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            dest;
   logic            dest_nxt;
   logic            capture;
   logic            timeout_hit;
   logic            mem_re_nxt;
   logic            ir_en;
   logic            mdr_en;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, counter and capture/timeout decisions.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      dest_nxt    = dest;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      mem_re_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (REQ) begin
               dest_nxt   = DEST_SEL;
               cnt_nxt    = '0;
               mem_re_nxt = 1'b1;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (MEM_RVALID) begin
               capture   = 1'b1;
               state_nxt = S_DONE;
            end else if (cnt == CW'(MAX_WAIT - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered outputs, destination latch, wait counter and sticky error.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         dest    <= DEST_IR;
         MEM_RE  <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         dest    <= dest_nxt;
         MEM_RE  <= mem_re_nxt;
         BUSY    <= (state_nxt != S_IDLE);
         DONE    <= capture;
         TIMEOUT <= timeout_hit | (TIMEOUT & ~CLR_ERR);
      end
   end

   assign ir_en  = capture & (dest == DEST_IR);
   assign mdr_en = capture & (dest == DEST_MDR);

   mcp_en_reg #(.WL(WL)) u_ir_reg (
      .clk (CLK),
      .rst (RST),
      .en  (ir_en),
      .d   (MEM_RDATA),
      .q   (IR_out)
   );

   mcp_en_reg #(.WL(WL)) u_mdr_reg (
      .clk (CLK),
      .rst (RST),
      .en  (mdr_en),
      .d   (MEM_RDATA),
      .q   (MDR_out)
   );

endmodule : mcp_mem_rd_demux
